fe_stage: RTL and testbench
===========================

FE_STAGE -- requirements
Module: fe_stage

Interface
REQ-001 Parameter START_PC, default 32'h0000_0000: PC fetched first after reset.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 from_DE_to_FE  input  `from_DE_to_FE_WIDTH (1)  bit 0 = pipeline_stall_DE.
REQ-005 from_AGEX_to_FE  input  1+`DBITS  {br_cond_AGEX, br_target_AGEX}; br_cond_AGEX=1 requests a redirect to br_target_AGEX.
REQ-006 imem_req  output  1  instruction-memory read request.
REQ-007 imem_addr  output  `DBITS  byte address of the requested word (= PC_FE).
REQ-008 imem_rdata  input  `INSTBITS  instruction word, valid when imem_ready=1.
REQ-009 imem_ready  input  1  imem_rdata valid for imem_addr in the current cycle.
REQ-010 FE_latch_out  output  `FE_latch_WIDTH  {inst, PC, pcplus, inst_count, bus_canary}, MSB first, widths `INSTBITS, `DBITS, `DBITS, `DBITS, `BUS_CANARY_WIDTH.

Function
REQ-011 fe_stage SHALL hold PC_FE (`DBITS), inst_count_FE (`DBITS), FE_latch, and a 2-bit FSM with states IDLE, FETCH, WAIT_MEM.
REQ-012 IDLE: imem_req=0, FE_latch gets a bubble (all zeros); next state FETCH unconditionally.
REQ-013 FETCH and WAIT_MEM: imem_req=1, imem_addr=PC_FE.
REQ-014 Per-cycle priority in FETCH/WAIT_MEM: redirect > stall > memory-not-ready > normal advance.
REQ-015 Redirect (br_cond_AGEX=1): PC_FE <= br_target_AGEX; FE_latch <= bubble; inst_count unchanged; next state FETCH; any pending or returned word in that cycle is discarded.
REQ-016 Stall (pipeline_stall_DE=1, no redirect): PC_FE, FE_latch, inst_count and state all held unchanged.
REQ-017 Not ready (imem_ready=0, no redirect, no stall): PC_FE held; FE_latch <= bubble; next state WAIT_MEM.
REQ-018 Normal advance (imem_ready=1, no redirect, no stall): FE_latch <= {imem_rdata, PC_FE, PC_FE+4, inst_count_FE+1, `BUS_CANARY_VALUE}; PC_FE <= PC_FE+4; inst_count_FE <= inst_count_FE+1; next state FETCH.
REQ-019 inst_count_FE SHALL count only instructions written into FE_latch (not bubbles, not stalled cycles); the value in the latch is the post-increment count.
REQ-020 PC+4 and inst_count+1 SHALL wrap modulo 2^`DBITS with no flag.
REQ-021 br_target_AGEX SHALL be used as-is (no alignment check).
REQ-022 A bubble SHALL have all fields zero, including bus_canary.
REQ-023 FE_latch_out SHALL be driven directly from FE_latch, with no combinational path from inputs.

Reset
REQ-024 Asserting reset at any time SHALL immediately set PC_FE=START_PC, inst_count_FE=0, FE_latch=0, state=IDLE; imem_req=0 while reset is high.
REQ-025 Reset asserted mid-wait or mid-stall SHALL abandon the pending fetch; no pre-reset word may reach FE_latch.

Verification
REQ-026 Reset release, imem_ready=1, no stall -> cycle 1 bubble; cycle 2 latch {inst@0x0, PC=0x0, pcplus=0x4, count=1, canary}; cycle 3 PC=0x4, count=2.
REQ-027 Stall held 3 cycles with PC_FE=0x8 -> FE_latch_out and imem_addr=0x8 constant for 3 cycles; after release, count resumes +1 with no skipped or duplicated PC.
REQ-028 imem_ready=0 for 2 cycles at PC 0xC -> two bubbles, state WAIT_MEM; on ready, latch PC=0xC, pcplus=0x10.
REQ-029 br_cond_AGEX=1, target 0x40, with stall=1 and imem_ready=0 in the same cycle -> bubble latched; next cycle imem_addr=0x40; count unchanged.
REQ-030 PC_FE=32'hFFFF_FFFC, normal advance -> latched pcplus=0x0; next imem_addr=0x0.
REQ-031 Async reset pulse mid-cycle during WAIT_MEM -> outputs zero immediately, before the next clock edge; first fetch after release is START_PC.

Source files
------------

// File: rtl/fe_stage.sv
// fe_stage: instruction fetch stage.
// Holds the fetch PC, the fetched-instruction count and the FE->DE pipeline
// latch. It issues one instruction-memory request per cycle and reacts to
// branch redirects from AGEX and stalls from DE.

`ifndef DBITS
`define DBITS 32
`endif
`ifndef INSTBITS
`define INSTBITS 32
`endif
`ifndef from_DE_to_FE_WIDTH
`define from_DE_to_FE_WIDTH 1
`endif
`ifndef BUS_CANARY_WIDTH
`define BUS_CANARY_WIDTH 16
`endif
`ifndef BUS_CANARY_VALUE
`define BUS_CANARY_VALUE 16'hEBEB
`endif
`ifndef FE_latch_WIDTH
`define FE_latch_WIDTH (`INSTBITS + 3 * `DBITS + `BUS_CANARY_WIDTH)
`endif

module fe_stage #(
  parameter logic [`DBITS-1:0] START_PC = 32'h0000_0000
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [`from_DE_to_FE_WIDTH-1:0] from_DE_to_FE,
  input  logic [`DBITS:0]                 from_AGEX_to_FE,
  output logic                            imem_req,
  output logic [`DBITS-1:0]               imem_addr,
  input  logic [`INSTBITS-1:0]            imem_rdata,
  input  logic                            imem_ready,
  output logic [`FE_latch_WIDTH-1:0]      FE_latch_out
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH    = 2'd1,
    WAIT_MEM = 2'd2
  } fe_state_t;

  fe_state_t                     state_r;
  fe_state_t                     state_next_s;
  logic [`DBITS-1:0]             pc_fe_r;
  logic [`DBITS-1:0]             pc_next_s;
  logic [`DBITS-1:0]             inst_count_r;
  logic [`DBITS-1:0]             count_next_s;
  logic [`FE_latch_WIDTH-1:0]    fe_latch_r;
  logic [`FE_latch_WIDTH-1:0]    latch_next_s;

  logic                          stall_de_s;
  logic                          br_cond_s;
  logic [`DBITS-1:0]             br_target_s;
  logic [`DBITS-1:0]             pc_plus4_s;
  logic [`DBITS-1:0]             count_plus1_s;

  // Unpack upstream control buses; wrap-around adders need no carry out.
  always_comb begin
    stall_de_s    = from_DE_to_FE[0];
    br_cond_s     = from_AGEX_to_FE[`DBITS];
    br_target_s   = from_AGEX_to_FE[`DBITS-1:0];
    pc_plus4_s    = pc_fe_r + 32'd4;
    count_plus1_s = inst_count_r + 32'd1;
  end

  // Next-state and next-latch selection: redirect > stall > not ready > advance.
  always_comb begin
    state_next_s = state_r;
    pc_next_s    = pc_fe_r;
    count_next_s = inst_count_r;
    latch_next_s = fe_latch_r;
    case (state_r)
      IDLE: begin
        latch_next_s = '0;
        state_next_s = FETCH;
      end
      FETCH, WAIT_MEM: begin
        if (br_cond_s) begin
          // Any word returned this cycle belongs to the wrong path.
          pc_next_s    = br_target_s;
          latch_next_s = '0;
          state_next_s = FETCH;
        end else if (stall_de_s) begin
          state_next_s = state_r;
        end else if (!imem_ready) begin
          latch_next_s = '0;
          state_next_s = WAIT_MEM;
        end else begin
          latch_next_s = {imem_rdata, pc_fe_r, pc_plus4_s, count_plus1_s,
                          `BUS_CANARY_VALUE};
          pc_next_s    = pc_plus4_s;
          count_next_s = count_plus1_s;
          state_next_s = FETCH;
        end
      end
      default: begin
        latch_next_s = '0;
        state_next_s = IDLE;
      end
    endcase
  end

  // Stage registers; reset abandons any outstanding fetch immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      pc_fe_r      <= START_PC;
      inst_count_r <= 32'd0;
      fe_latch_r   <= '0;
    end else begin
      state_r      <= state_next_s;
      pc_fe_r      <= pc_next_s;
      inst_count_r <= count_next_s;
      fe_latch_r   <= latch_next_s;
    end
  end

  // Outputs come straight from registers, never from stage inputs.
  always_comb begin
    imem_req     = (state_r == FETCH) || (state_r == WAIT_MEM);
    imem_addr    = pc_fe_r;
    FE_latch_out = fe_latch_r;
  end

endmodule

// File: tb/tb_fe_stage.sv
// Directed, table-driven bench for fe_stage with a simple instruction memory
// whose returned word is a fixed function of the requested address.
`timescale 1ns/1ps

module tb_fe_stage;

  localparam int          LW     = 144;
  localparam logic [15:0] CANARY = 16'hEBEB;

  logic          clk;
  logic          reset;
  logic [0:0]    from_DE_to_FE;
  logic [32:0]   from_AGEX_to_FE;
  logic          imem_req;
  logic [31:0]   imem_addr;
  logic [31:0]   imem_rdata;
  logic          imem_ready;
  logic [LW-1:0] FE_latch_out;

  int n_vec;
  int n_err;

  fe_stage #(.START_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .reset           (reset),
    .from_DE_to_FE   (from_DE_to_FE),
    .from_AGEX_to_FE (from_AGEX_to_FE),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .imem_ready      (imem_ready),
    .FE_latch_out    (FE_latch_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] inst_at(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  // Memory model answers whatever address is presented.
  assign imem_rdata = inst_at(imem_addr);

  function automatic logic [LW-1:0] mk(input logic [31:0] pc, input logic [31:0] pcplus,
                                       input logic [31:0] cnt);
    return {inst_at(pc), pc, pcplus, cnt, CANARY};
  endfunction

  typedef struct {
    logic          stall;
    logic          br;
    logic [31:0]   target;
    logic          ready;
    logic          exp_req;
    logic [31:0]   exp_addr;
    logic [LW-1:0] exp_latch;
  } vec_t;

  vec_t tbl[15];

  task automatic chk_latch(input string name, input logic [LW-1:0] exp);
    n_vec++;
    if (FE_latch_out !== exp) begin
      n_err++;
      $display("FAIL %s latch: got %h want %h", name, FE_latch_out, exp);
    end
  endtask

  task automatic chk_addr(input string name, input logic req, input logic [31:0] addr);
    n_vec++;
    if (imem_req !== req || imem_addr !== addr) begin
      n_err++;
      $display("FAIL %s req/addr: got %b/%h want %b/%h", name, imem_req, imem_addr, req, addr);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    from_DE_to_FE = 1'b0;
    from_AGEX_to_FE = 33'd0;
    imem_ready = 1'b1;

    // stall br target ready | exp_req exp_addr exp_latch
    tbl[0]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0000, '0};
    tbl[1]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0004, mk(32'h0, 32'h4, 32'd1)};
    tbl[2]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0008, mk(32'h4, 32'h8, 32'd2)};
    tbl[3]  = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0008, mk(32'h4, 32'h8, 32'd2)};
    tbl[4]  = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0008, mk(32'h4, 32'h8, 32'd2)};
    tbl[5]  = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0008, mk(32'h4, 32'h8, 32'd2)};
    tbl[6]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_000C, mk(32'h8, 32'hC, 32'd3)};
    tbl[7]  = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_000C, '0};
    tbl[8]  = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_000C, '0};
    tbl[9]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0010, mk(32'hC, 32'h10, 32'd4)};
    tbl[10] = '{1'b1, 1'b1, 32'h40, 1'b0, 1'b1, 32'h0000_0040, '0};
    tbl[11] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0044, mk(32'h40, 32'h44, 32'd5)};
    tbl[12] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, 32'hFFFF_FFFC, '0};
    tbl[13] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0000, mk(32'hFFFF_FFFC, 32'h0, 32'd6)};
    tbl[14] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0004, mk(32'h0, 32'h4, 32'd7)};

    // Reset state.
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_addr("reset", 1'b0, 32'h0);
    chk_latch("reset", '0);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      from_DE_to_FE   = tbl[i].stall;
      from_AGEX_to_FE = {tbl[i].br, tbl[i].target};
      imem_ready      = tbl[i].ready;
      @(posedge clk);
      #1;
      chk_addr($sformatf("vec%0d", i), tbl[i].exp_req, tbl[i].exp_addr);
      chk_latch($sformatf("vec%0d", i), tbl[i].exp_latch);
    end

    // Enter WAIT_MEM at PC 0x4, then pulse reset between clock edges.
    from_DE_to_FE   = 1'b0;
    from_AGEX_to_FE = 33'd0;
    imem_ready      = 1'b0;
    @(posedge clk);
    #1;
    chk_addr("wait_pre_rst", 1'b1, 32'h4);
    chk_latch("wait_pre_rst", '0);
    #2;
    reset = 1'b1;
    #1;
    chk_addr("async_rst", 1'b0, 32'h0);
    chk_latch("async_rst", '0);
    imem_ready = 1'b1;
    @(posedge clk);
    #1;
    chk_addr("rst_held", 1'b0, 32'h0);
    chk_latch("rst_held", '0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk_addr("post_rst_idle", 1'b1, 32'h0);
    chk_latch("post_rst_idle", '0);
    @(posedge clk);
    #1;
    chk_addr("post_rst_fetch", 1'b1, 32'h4);
    chk_latch("post_rst_fetch", mk(32'h0, 32'h4, 32'd1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
